// File: rtl/ncount_mod_chain_if.sv
// Control/data bundle for the cascaded modulo counter.
// Carries no timing of its own; all outputs are driven by the counter.
// No backpressure; the counter accepts a command on every clock edge.
interface ncount_mod_chain_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 4
);
    logic                      sclr;
    logic                      load;
    logic [DIGITS*WIDTH-1:0]   load_val;
    logic                      en;
    logic                      up;
    logic [DIGITS*WIDTH-1:0]   out;
    logic [DIGITS-1:0]         digit_cout;
    logic                      cout;
    logic                      at_max;
    logic                      at_min;

    // Command side drives controls and observes the count.
    modport master (
        output sclr, load, load_val, en, up,
        input  out, digit_cout, cout, at_max, at_min
    );

    // Counter side consumes controls and drives the count.
    modport slave (
        input  sclr, load, load_val, en, up,
        output out, digit_cout, cout, at_max, at_min
    );
endinterface

// File: rtl/ncount_mod_chain.sv
// Cascade of DIGITS modulo-MOD digits with enable, up/down, load, clear, optional saturate.
// Latency: count, wrap pulses registered 1 cycle after the edge; at_max/at_min combinational from out.
// No backpressure; every edge applies sclr > load > en > hold.
module ncount_mod_chain #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 10,
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                clr_n,
    ncount_mod_chain_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MOD - 1);
    // One extra bit so the clamp compare works even when MOD == 2**WIDTH.
    localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MOD);

    logic [DIGITS*WIDTH-1:0] cnt_q;
    logic [DIGITS*WIDTH-1:0] cnt_d;
    logic [DIGITS-1:0]       dcout_q;
    logic [DIGITS-1:0]       dcout_d;
    logic                    cout_q;
    logic                    cout_d;
    logic                    all_max;
    logic                    all_min;
    logic                    sat_hold;
    logic                    step;
    logic                    hit;
    logic [WIDTH-1:0]        dig;
    logic [WIDTH-1:0]        ld_dig;

    // Whole-chain boundary detection, taken straight from the registered count.
    always_comb begin
        all_max = 1'b1;
        all_min = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_q[k*WIDTH +: WIDTH] != MAX_D) all_max = 1'b0;
            if (cnt_q[k*WIDTH +: WIDTH] != '0)    all_min = 1'b0;
        end
    end

    // In saturate mode the chain freezes instead of crossing the boundary it is heading for.
    assign sat_hold = (SATURATE != 0) && (bus.up ? all_max : all_min);

    // Next-state: step is the ripple condition, true while every lower digit sits at its wrap value.
    always_comb begin
        cnt_d   = cnt_q;
        dcout_d = '0;
        cout_d  = 1'b0;
        step    = 1'b1;
        hit     = 1'b0;
        dig     = '0;
        ld_dig  = '0;
        if (bus.sclr) begin
            cnt_d = '0;
        end else if (bus.load) begin
            for (int k = 0; k < DIGITS; k++) begin
                ld_dig = bus.load_val[k*WIDTH +: WIDTH];
                cnt_d[k*WIDTH +: WIDTH] = ({1'b0, ld_dig} >= MOD_V) ? MAX_D : ld_dig;
            end
        end else if (bus.en && !sat_hold) begin
            for (int k = 0; k < DIGITS; k++) begin
                dig = cnt_q[k*WIDTH +: WIDTH];
                hit = bus.up ? (dig == MAX_D) : (dig == '0);
                if (step) begin
                    dcout_d[k] = hit;
                    if (bus.up) cnt_d[k*WIDTH +: WIDTH] = hit ? '0    : dig + WIDTH'(1);
                    else        cnt_d[k*WIDTH +: WIDTH] = hit ? MAX_D : dig - WIDTH'(1);
                end
                step = step & hit;
            end
            // step still set here means the top digit wrapped too.
            cout_d = (SATURATE == 0) && step;
        end
    end

    // Count and wrap-pulse registers; clr_n clears them without waiting for a clock.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            dcout_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dcout_q <= dcout_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.out        = cnt_q;
    assign bus.digit_cout = dcout_q;
    assign bus.cout       = cout_q;
    assign bus.at_max     = all_max;
    assign bus.at_min     = all_min;
endmodule

// File: tb/tb_ncount_mod_chain.sv
// Bench for ncount_mod_chain: a wrapping and a saturating 2-digit BCD chain driven in lockstep.
// Expected results come from an integer model and are queued per edge.
// Outputs sampled 1 time unit after each rising edge.
module tb_ncount_mod_chain;
    localparam int W     = 4;
    localparam int M     = 10;
    localparam int D     = 2;
    localparam int TOTAL = M ** D;

    typedef struct packed {
        logic [D*W-1:0] out;
        logic [D-1:0]   dc;
        logic           co;
        logic           amax;
        logic           amin;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    ncount_mod_chain_if #(.WIDTH(W), .DIGITS(D)) bw ();
    ncount_mod_chain_if #(.WIDTH(W), .DIGITS(D)) bs ();

    ncount_mod_chain #(.WIDTH(W), .MOD(M), .DIGITS(D), .SATURATE(0)) dut_w (
        .clk(clk), .clr_n(clr_n), .bus(bw)
    );
    ncount_mod_chain #(.WIDTH(W), .MOD(M), .DIGITS(D), .SATURATE(1)) dut_s (
        .clk(clk), .clr_n(clr_n), .bus(bs)
    );

    int   n_w = 0;
    int   n_s = 0;
    exp_t q_w[$];
    exp_t q_s[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [D*W-1:0] pack(input int n);
        logic [D*W-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < D; k++) begin
            r[k*W +: W] = W'((n / p) % M);
            p = p * M;
        end
        return r;
    endfunction

    // Integer model: the chain is a number 0..TOTAL-1; digit k wraps when the low k+1 digits roll over.
    task automatic model(inout int n, input bit sat, input logic sc, input logic ld,
                         input logic [D*W-1:0] lv, input logic e, input logic u, output exp_t x);
        int old;
        int p;
        int v;
        bit hold;
        old = n;
        x = '0;
        if (sc) begin
            n = 0;
        end else if (ld) begin
            n = 0;
            p = 1;
            for (int k = 0; k < D; k++) begin
                v = int'(lv[k*W +: W]);
                if (v > M - 1) v = M - 1;
                n = n + v * p;
                p = p * M;
            end
        end else if (e) begin
            hold = sat && ((u && old == TOTAL - 1) || (!u && old == 0));
            if (!hold) begin
                p = M;
                for (int k = 0; k < D; k++) begin
                    x.dc[k] = u ? (((old + 1) % p) == 0) : ((old % p) == 0);
                    p = p * M;
                end
                n    = u ? (old + 1) % TOTAL : (old + TOTAL - 1) % TOTAL;
                x.co = !sat && (u ? (old == TOTAL - 1) : (old == 0));
            end
        end
        x.out  = pack(n);
        x.amax = (n == TOTAL - 1);
        x.amin = (n == 0);
    endtask

    task automatic compare(input string tag, input exp_t got, input exp_t exp);
        chk({tag, ".out"},        32'(got.out),  32'(exp.out));
        chk({tag, ".digit_cout"}, 32'(got.dc),   32'(exp.dc));
        chk({tag, ".cout"},       32'(got.co),   32'(exp.co));
        chk({tag, ".at_max"},     32'(got.amax), 32'(exp.amax));
        chk({tag, ".at_min"},     32'(got.amin), 32'(exp.amin));
    endtask

    task automatic cycle(input logic sc, input logic ld, input logic [D*W-1:0] lv,
                         input logic e, input logic u);
        exp_t xw;
        exp_t xs;
        exp_t gw;
        exp_t gs;
        bw.sclr = sc; bw.load = ld; bw.load_val = lv; bw.en = e; bw.up = u;
        bs.sclr = sc; bs.load = ld; bs.load_val = lv; bs.en = e; bs.up = u;
        model(n_w, 1'b0, sc, ld, lv, e, u, xw);
        q_w.push_back(xw);
        model(n_s, 1'b1, sc, ld, lv, e, u, xs);
        q_s.push_back(xs);
        @(posedge clk);
        #1;
        gw.out = bw.out; gw.dc = bw.digit_cout; gw.co = bw.cout; gw.amax = bw.at_max; gw.amin = bw.at_min;
        gs.out = bs.out; gs.dc = bs.digit_cout; gs.co = bs.cout; gs.amax = bs.at_max; gs.amin = bs.at_min;
        compare("wrap", gw, q_w.pop_front());
        compare("sat",  gs, q_s.pop_front());
    endtask

    initial begin
        bw.sclr = 1'b0; bw.load = 1'b0; bw.load_val = '0; bw.en = 1'b0; bw.up = 1'b1;
        bs.sclr = 1'b0; bs.load = 1'b0; bs.load_val = '0; bs.en = 1'b0; bs.up = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wrap.out",    32'(bw.out),        32'h0);
        chk("rst.wrap.dcout",  32'(bw.digit_cout), 32'h0);
        chk("rst.wrap.cout",   32'(bw.cout),       32'h0);
        chk("rst.wrap.at_min", 32'(bw.at_min),     32'h1);
        chk("rst.wrap.at_max", 32'(bw.at_max),     32'h0);
        chk("rst.sat.out",     32'(bs.out),        32'h0);
        @(negedge clk);
        clr_n = 1'b1;

        // Up across the 99 -> 00 boundary.
        cycle(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        // Down across the 00 -> 99 boundary.
        cycle(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // Load clamp, sclr over load, load over en.
        cycle(1'b0, 1'b1, 8'h3F, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
        // Saturate at all-max, then step down.
        cycle(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // Saturate at all-zero going down.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // Enable gating around a digit carry.
        cycle(1'b0, 1'b1, 8'h09, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Free-run to 0x47, then drop clr_n between edges.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (47) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst.wrap.out",   32'(bw.out),        32'h0);
        chk("arst.wrap.dcout", 32'(bw.digit_cout), 32'h0);
        chk("arst.wrap.cout",  32'(bw.cout),       32'h0);
        chk("arst.wrap.at_min",32'(bw.at_min),     32'h1);
        chk("arst.sat.out",    32'(bs.out),        32'h0);
        n_w = 0;
        n_s = 0;
        @(posedge clk);
        #1;
        chk("arst.held.out",   32'(bw.out),        32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("arst.resume.out", 32'(bw.out),        32'h01);

        // Mixed random traffic, both directions.
        for (int i = 0; i < 80; i++) begin
            cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0),
                  (D*W)'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
